coco_mem_bridge: RTL

//  Bridges the multi-cycle datapath's memory port (Adr/WData/MemWe/RData/MemReady) to an

---
 rtl/coco_mem_bridge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/coco_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coco_mem_bridge: datapath memory port to ack-based word bus bridge with   |
// | byte enables, store lane replication, alignment check and bus timeout.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module coco_mem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemReq,
  input  logic        MemWe,
  input  logic [1:0]  MemSize,
  input  logic [31:0] Adr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        AlignErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [29:0] BusAddr,
  output logic [3:0]  BusBE,
  output logic [31:0] BusWData,
  input  logic [31:0] BusRData,
  input  logic        BusAck
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [29:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              align_q, align_d;

  logic              w_misaligned;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;

  // Reserved size 11 behaves as a word access.
  always_comb begin
    w_misaligned = ((MemSize == 2'b01) && Adr[0]) || (MemSize[1] && (Adr[1:0] != 2'b00));
    w_be         = 4'b1111;
    w_wdata      = WData;
    case (MemSize)
      2'b00: begin
        w_be    = 4'b1000 >> Adr[1:0];
        w_wdata = {4{WData[7:0]}};
      end
      2'b01: begin
        w_be    = Adr[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{WData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WData;
      end
    endcase
    if (!MemWe) begin
      w_be = 4'b1111;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    align_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemReq) begin
          if (w_misaligned) begin
            align_d = 1'b1;
          end else begin
            addr_d  = Adr[31:2];
            we_d    = MemWe;
            be_d    = w_be;
            wd_d    = w_wdata;
            cnt_d   = '0;
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack in the final wait cycle still completes the transaction.
        if (BusAck) begin
          if (!we_q) begin
            rdata_d = BusRData;
          end
          req_d   = 1'b0;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == C_CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      align_q <= align_d;
    end
  end

  assign RData    = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;
  assign AlignErr = align_q;
  assign BusReq   = req_q;
  assign BusWe    = we_q;
  assign BusAddr  = addr_q;
  assign BusBE    = be_q;
  assign BusWData = wd_q;

endmodule
`default_nettype wire
